// File: rtl/if_id_stage_reg.sv
// if_id_stage_reg: fetch-to-decode pipeline boundary register.
// Captures {pc, insn} beats from fetch, precomputes pc+4 and presents them
// to decode through a 2-entry skid buffer. Because of that buffer, if_ready
// depends only on registered state. A flush kills all buffered beats. The
// stall counter saturates.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   if_valid     fetch beat valid
//   if_ready     stage can accept a beat (decoded from state flops)
//   if_pc        PC of fetched instruction
//   if_insn      fetched instruction word
//   flush        synchronous kill of buffered beats
//   id_valid     decode beat valid (decoded from state flops)
//   id_ready     decode accepts a beat
//   id_pc        PC of presented beat
//   id_pc_plus4  id_pc + 4 modulo 2^XLEN
//   id_insn      presented instruction (NOP_INSN when id_valid=0)
//   stall_cnt    saturating count of cycles with id_valid & !id_ready
module if_id_stage_reg #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_insn,
  input  logic             flush,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_pc_plus4,
  output logic [31:0]      id_insn,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned INSN_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [INSN_W-1:0] insn;
  } beat_t;

  localparam beat_t RESET_BEAT = '{pc: '0, pc_plus4: '0, insn: NOP_INSN};

  state_t state;
  beat_t  main_q;
  beat_t  skid_q;
  beat_t  in_beat;
  logic   in_xfer;
  logic   out_xfer;

  // Handshake flags come from the state register only; no id_ready -> if_ready path.
  assign id_valid = (state != EMPTY);
  assign if_ready = (state != TWO);
  assign in_xfer  = if_valid & if_ready;
  assign out_xfer = id_valid & id_ready;

  // Capture-time pc+4, carry discarded.
  assign in_beat = '{pc: if_pc, pc_plus4: if_pc + XLEN'(4), insn: if_insn};

  assign id_pc       = main_q.pc;
  assign id_pc_plus4 = main_q.pc_plus4;
  assign id_insn     = main_q.insn;

  // Skid-buffer FSM with MAIN/SKID storage; flush has top priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= RESET_BEAT;
      skid_q <= RESET_BEAT;
    end else if (flush) begin
      state       <= EMPTY;
      main_q.insn <= NOP_INSN;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q <= in_beat;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_beat;
          end else if (in_xfer) begin
            skid_q <= in_beat;
            state  <= TWO;
          end else if (out_xfer) begin
            // pc fields hold; only the insn drops to a bubble
            main_q.insn <= NOP_INSN;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          main_q.insn <= NOP_INSN;
        end
      endcase
    end
  end

  // Saturating stall counter; flush does not touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (id_valid && !id_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed testbench for if_id_stage_reg.
module tb_if_id_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_insn;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_insn;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_id_stage_reg dut (
    .clk         (clk),
    .reset       (reset),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_insn     (if_insn),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_insn     (id_insn),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs, advance one edge, settle 1 time unit after it.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                      input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_insn  = insn;
    id_ready = rdy;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; if_valid = 1'b0; if_pc = '0; if_insn = '0; id_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_during", {63'd0, id_valid}, 64'd0);
    reset = 1'b1;
    #1;
    check("rst_valid", {63'd0, id_valid}, 64'd0);
    check("rst_insn", {32'd0, id_insn}, {32'd0, NOP});
    check("rst_ready", {63'd0, if_ready}, 64'd1);
    check("rst_stall", {48'd0, stall_cnt}, 64'd0);
    check("rst_pc", {32'd0, id_pc}, 64'd0);
    check("rst_pc4", {32'd0, id_pc_plus4}, 64'd0);

    // Streaming at full throughput
    step(1'b1, 32'h0, 32'hA, 1'b1, 1'b0);
    check("s0_valid", {63'd0, id_valid}, 64'd1);
    check("s0_pc", {32'd0, id_pc}, 64'h0);
    check("s0_pc4", {32'd0, id_pc_plus4}, 64'h4);
    check("s0_insn", {32'd0, id_insn}, 64'hA);
    step(1'b1, 32'h4, 32'hB, 1'b1, 1'b0);
    check("s1_pc", {32'd0, id_pc}, 64'h4);
    check("s1_pc4", {32'd0, id_pc_plus4}, 64'h8);
    check("s1_insn", {32'd0, id_insn}, 64'hB);
    step(1'b1, 32'h8, 32'hC, 1'b1, 1'b0);
    check("s2_pc", {32'd0, id_pc}, 64'h8);
    check("s2_pc4", {32'd0, id_pc_plus4}, 64'hC);
    check("s2_insn", {32'd0, id_insn}, 64'hC);
    check("s2_valid", {63'd0, id_valid}, 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("s3_valid", {63'd0, id_valid}, 64'd0);
    check("s3_insn", {32'd0, id_insn}, {32'd0, NOP});
    check("s3_pc_hold", {32'd0, id_pc}, 64'h8);
    check("s3_stall", {48'd0, stall_cnt}, 64'd0);

    // Back-pressure into the skid buffer
    step(1'b1, 32'h10, 32'h110, 1'b0, 1'b0);
    check("bp0_pc", {32'd0, id_pc}, 64'h10);
    check("bp0_ready", {63'd0, if_ready}, 64'd1);
    check("bp0_stall", {48'd0, stall_cnt}, 64'd0);
    step(1'b1, 32'h14, 32'h114, 1'b0, 1'b0);
    check("bp1_ready", {63'd0, if_ready}, 64'd0);
    check("bp1_pc", {32'd0, id_pc}, 64'h10);
    check("bp1_stall", {48'd0, stall_cnt}, 64'd1);
    step(1'b1, 32'h18, 32'h118, 1'b0, 1'b0);
    check("bp2_pc_stable", {32'd0, id_pc}, 64'h10);
    check("bp2_insn_stable", {32'd0, id_insn}, 64'h110);
    check("bp2_stall", {48'd0, stall_cnt}, 64'd2);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("bp3_pc", {32'd0, id_pc}, 64'h14);
    check("bp3_pc4", {32'd0, id_pc_plus4}, 64'h18);
    check("bp3_insn", {32'd0, id_insn}, 64'h114);
    check("bp3_ready", {63'd0, if_ready}, 64'd1);
    check("bp3_stall", {48'd0, stall_cnt}, 64'd2);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("bp4_valid", {63'd0, id_valid}, 64'd0);

    // Flush while full, with a beat offered in the same cycle
    step(1'b1, 32'h30, 32'h130, 1'b0, 1'b0);
    step(1'b1, 32'h34, 32'h134, 1'b0, 1'b0);
    check("fl0_ready", {63'd0, if_ready}, 64'd0);
    check("fl0_stall", {48'd0, stall_cnt}, 64'd3);
    step(1'b1, 32'h20, 32'h120, 1'b0, 1'b1);
    check("fl1_valid", {63'd0, id_valid}, 64'd0);
    check("fl1_insn", {32'd0, id_insn}, {32'd0, NOP});
    check("fl1_pc_hold", {32'd0, id_pc}, 64'h30);
    check("fl1_ready", {63'd0, if_ready}, 64'd1);
    check("fl1_stall", {48'd0, stall_cnt}, 64'd4);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("fl2_valid", {63'd0, id_valid}, 64'd0);
    step(1'b1, 32'h40, 32'h140, 1'b1, 1'b0);
    check("fl3_pc", {32'd0, id_pc}, 64'h40);
    check("fl3_pc4", {32'd0, id_pc_plus4}, 64'h44);
    check("fl3_insn", {32'd0, id_insn}, 64'h140);

    // pc+4 wrap
    step(1'b1, 32'hFFFF_FFFC, 32'h1FC, 1'b1, 1'b0);
    check("wrap_pc", {32'd0, id_pc}, 64'hFFFF_FFFC);
    check("wrap_pc4", {32'd0, id_pc_plus4}, 64'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("wrap_drain", {63'd0, id_valid}, 64'd0);

    // Asynchronous reset in the middle of a stall
    step(1'b1, 32'h50, 32'h150, 1'b0, 1'b0);
    step(1'b1, 32'h54, 32'h154, 1'b0, 1'b0);
    check("ar0_ready", {63'd0, if_ready}, 64'd0);
    check("ar0_stall", {48'd0, stall_cnt}, 64'd5);
    #2;
    reset = 1'b0;
    #1;
    check("ar1_valid", {63'd0, id_valid}, 64'd0);
    check("ar1_ready", {63'd0, if_ready}, 64'd1);
    check("ar1_stall", {48'd0, stall_cnt}, 64'd0);
    check("ar1_insn", {32'd0, id_insn}, {32'd0, NOP});
    check("ar1_pc", {32'd0, id_pc}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
